// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding-source select for one Execute-stage operand; Memory beats Writeback.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    // x0 never forwards; the younger M result shadows W
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding, data-memory wait tracking and activity counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int unsigned      WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    hz_state_t         state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              mem_wait, lw_stall;
    logic [1:0]        fwd_a, fwd_b;

    assign mem_wait = MemReqM & ~MemReadyM;
    assign lw_stall = ResultSrcE0 & (RdE != REG_X0) & ((RdE == Rs1D) | (RdE == Rs2D));

    fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    // Zero-latency pipeline controls; a memory wait freezes E and overrides branch/load-use
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst_n) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
            end
        end
    end

    // Memory-wait FSM next state and saturating wait-length count
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt != WAIT_MAX) begin
                        wait_next = WAIT_W'(wait_cnt + WAIT_W'(1));
                    end
                end else begin
                    state_next = RUN;
                    wait_next  = '0;
                end
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
    end

    // State, sticky timeout flag and saturating activity counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            MemErr   <= 1'b0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (mem_wait && (wait_cnt == WAIT_MAX)) begin
                MemErr <= 1'b1;
            end
            if (StallF && (StallCnt != CNT_MAX)) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (FlushD && (FlushCnt != CNT_MAX)) begin
                FlushCnt <= FlushCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a behavioural reference model.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int          CNT_SAT     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: consecutive wait edges, sticky error, counters
    int m_wait_run = 0;
    bit m_err      = 1'b0;
    int m_scnt     = 0;
    int m_fcnt     = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MemErr      (MemErr),
        .StallCnt    (StallCnt),
        .FlushCnt    (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int fwd_exp(input int rs, input int rdm, input int rdw,
                                   input bit wm, input bit ww);
        if (wm && rdm != 0 && rdm == rs) return 2;
        if (ww && rdw != 0 && rdw == rs) return 1;
        return 0;
    endfunction

    // One cycle: check combinational outputs, clock, then check registered state
    task automatic step();
        bit mw, lw, sf, sd, se, sm, fd, fe, fw;
        int ea, eb;
        #1;
        mw = MemReqM && !MemReadyM;
        lw = ResultSrcE0 && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        {sf, sd, se, sm, fd, fe, fw} = '0;
        ea = 0;
        eb = 0;
        if (rst_n) begin
            ea = fwd_exp(int'(Rs1E), int'(RdM), int'(RdW), RegWriteM, RegWriteW);
            eb = fwd_exp(int'(Rs2E), int'(RdM), int'(RdW), RegWriteM, RegWriteW);
            if (mw) begin
                {sf, sd, se, sm, fw} = '1;
            end else begin
                sf = lw;
                sd = lw;
                fd = PCSrcE;
                fe = lw || PCSrcE;
            end
        end
        chk("StallF", 32'(StallF), 32'(sf));
        chk("StallD", 32'(StallD), 32'(sd));
        chk("StallE", 32'(StallE), 32'(se));
        chk("StallM", 32'(StallM), 32'(sm));
        chk("FlushD", 32'(FlushD), 32'(fd));
        chk("FlushE", 32'(FlushE), 32'(fe));
        chk("FlushW", 32'(FlushW), 32'(fw));
        chk("ForwardAE", 32'(ForwardAE), 32'(ea));
        chk("ForwardBE", 32'(ForwardBE), 32'(eb));
        @(posedge clk);
        if (!rst_n) begin
            m_wait_run = 0;
            m_err      = 1'b0;
            m_scnt     = 0;
            m_fcnt     = 0;
        end else begin
            if (mw) begin
                if (m_wait_run >= int'(MEM_TIMEOUT)) m_err = 1'b1;
                m_wait_run++;
            end else begin
                m_wait_run = 0;
            end
            if (sf && m_scnt < CNT_SAT) m_scnt++;
            if (fd && m_fcnt < CNT_SAT) m_fcnt++;
        end
        #1;
        chk("MemErr", 32'(MemErr), 32'(m_err));
        chk("StallCnt", 32'(StallCnt), 32'(m_scnt));
        chk("FlushCnt", 32'(FlushCnt), 32'(m_fcnt));
    endtask

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        // outputs gated while in reset even with hazards present
        MemReqM = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
        step();
        idle_inputs();
        rst_n = 1'b1;
        step();

        // load-use
        ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        step();
        chk("loaduse_cnt", 32'(StallCnt), 32'd1);
        idle_inputs();

        // forwarding priority
        Rs1E = 5'd3; Rs2E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1;
        step();
        RegWriteM = 1'b0;
        step();
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        step();
        idle_inputs();

        // branch with concurrent load-use
        PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        step();
        idle_inputs();

        // short memory wait with a branch pending
        MemReqM = 1'b1; PCSrcE = 1'b1;
        repeat (3) step();
        MemReadyM = 1'b1;
        step();
        idle_inputs();
        step();

        // timeout: six wait cycles, then ready; flag stays until reset
        MemReqM = 1'b1;
        repeat (6) step();
        MemReadyM = 1'b1;
        step();
        idle_inputs();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // reset in the middle of a wait
        MemReqM = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle_inputs();
        step();

        // stall counter saturation
        ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        repeat (20) step();
        chk("stall_sat", 32'(StallCnt), 32'(CNT_SAT));
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3));
            RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = 1'($urandom_range(0, 1));
            PCSrcE      = ($urandom_range(0, 3) == 0);
            MemReqM     = ($urandom_range(0, 2) != 0);
            MemReadyM   = ($urandom_range(0, 3) == 0);
            rst_n       = ($urandom_range(0, 59) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
